bar_game_ctrl: RTL
==================

# bar_game_ctrl

Game-state engine for the falling-bar game. It consumes debounced player buttons and a once-per-frame tick, and advances the bar. It checks each bar crossing against the player column, tracks lives, score and speed, and drives the position and status inputs of the `vga` renderer directly (`barpos`, `holepos`, `plrpos`, `lives`, `cyclesneeded`). It sits immediately upstream of `vga`, in the same `dclk` domain.

## Interface
Parameters:
- `BAR_STEP`, 4: pixels the bar descends per step.
- `BAR_BOTTOM`, 440: bar row at which a crossing is evaluated. `BAR_BOTTOM + BAR_STEP` must be ≤ 511.
- `INIT_CYCLES`, 4: starting `cyclesneeded`, in the range 1..7.

Ports:
- `dclk` in 1: single system clock.
- `clr` in 1: reset, asynchronous, active-high.
- `tick` in 1: one-cycle pulse per video frame.
- `btn_l` in 1: move left, debounced level, synchronous to `dclk`.
- `btn_r` in 1: move right, debounced level, synchronous to `dclk`.
- `btn_start` in 1: start/restart, debounced level, synchronous to `dclk`.
- `barpos` out 9: bar top row, 0..`BAR_BOTTOM`.
- `holepos` out 4: hole column in the bar, 0..15.
- `plrpos` out 4: player column, 0..15.
- `lives` out 2: remaining lives.
- `cyclesneeded` out 3: ticks per bar step, 1..7.
- `score` out 8: bars passed, saturating.
- `gameover` out 1: high in the OVER state.

## Operation
- FSM states: IDLE, PLAY, OVER. Reset enters IDLE.
- Reset values:
  - `barpos` = 0, `holepos` = 5, `plrpos` = 7, `lives` = 3.
  - `cyclesneeded` = `INIT_CYCLES`, `score` = 0, `gameover` = 0.
  - Internal `tickcnt` = 0; 8-bit LFSR = 8'hA5.
  - Button history registers = 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every `dclk` in all states and is never reset except by `clr`.
- Button edge detection: `rise_x = btn_x & ~btn_x_q`, where `btn_x_q` is the previous-cycle sample. A held button produces exactly one action.
- IDLE:
  - `rise_start` loads `holepos` from `lfsr[3:0]`, clears `tickcnt` and goes to PLAY.
  - All other inputs are ignored.
- PLAY, movement:
  - `rise_l` with `plrpos` > 0 decrements `plrpos`.
  - `rise_r` with `plrpos` < 15 increments `plrpos`.
  - `rise_l` and `rise_r` in the same cycle: no move.
  - At column 0 a left edge and at column 15 a right edge have no effect (saturate, never wrap).
- PLAY, on `tick`:
  - If `tickcnt` ≠ `cyclesneeded` − 1: `tickcnt` increments.
  - Otherwise `tickcnt` clears and a step occurs.
- Step with `barpos` < `BAR_BOTTOM`: `barpos` += `BAR_STEP`, clamped to `BAR_BOTTOM`.
- Step with `barpos` = `BAR_BOTTOM`: crossing evaluation.
  - Pass (`plrpos` == `holepos`):
    - `score` += 1, saturating at 255.
    - If the new `score[1:0]` == 0 and `cyclesneeded` > 1, `cyclesneeded` decrements.
    - `barpos` ← 0 and `holepos` ← `lfsr[3:0]`.
  - Miss with `lives` > 1: `lives` −= 1, `barpos` ← 0, `holepos` ← `lfsr[3:0]`.
  - Miss with `lives` == 1: `lives` ← 0, go to OVER. `barpos` and `holepos` hold.
- OVER:
  - `gameover` = 1; bar, player and `tickcnt` are frozen; `tick`, `btn_l` and `btn_r` are ignored.
  - `rise_start` restores every game register to its reset value except `holepos` (← `lfsr[3:0]`) and the LFSR, clears `gameover` and goes directly to PLAY.
- PLAY ignores `rise_start`.

## Timing
- All outputs are registered and change only on a `dclk` rising edge, or asynchronously on `clr`.
- Button: edge sampled at edge k gives the updated `plrpos` visible after edge k. Latency is 1 cycle from the first high sample.
- Simultaneous move and crossing in the same cycle: the evaluation uses the pre-update `plrpos`; the move still takes effect.
- Step cadence is one step per `cyclesneeded` ticks. A new `cyclesneeded` value applies from the next `tickcnt` comparison.
- `clr` mid-game: all outputs reach their reset values immediately; the block is in IDLE at the first edge after release.
- `tick` in IDLE or OVER does not touch `tickcnt`.

## Test plan
- Reset check: assert `clr` mid-PLAY.
  - Outputs immediately read 0/5/7/3/`INIT_CYCLES`/0/0.
  - Start edge → PLAY, `holepos` = LFSR value at that edge.
- Cadence: `INIT_CYCLES` = 4, 4 ticks → `barpos` 0→4. After 440/4 steps `barpos` = 440. The next 4 ticks evaluate the crossing.
- Movement: hold `btn_r` 50 cycles → `plrpos` 7→8 only. Pulse `btn_r` 10 more times → saturates at 15. `btn_l`+`btn_r` together → unchanged.
- Pass / speed-up: align `plrpos` to `holepos` for 4 consecutive crossings.
  - `score` = 4, `cyclesneeded` 4→3, `barpos` = 0 after each crossing.
  - Repeat until `cyclesneeded` floors at 1.
- Miss → game over: misalign for 3 crossings.
  - `lives` 3→2→1→0 and `gameover` = 1.
  - `barpos` holds at 440; ticks and buttons are ignored.
  - Start edge → `lives` = 3, `score` = 0, PLAY.
- Boundary: a move edge in the same cycle as the evaluating tick with `plrpos` = `holepos` − 1 → counted as a miss; `plrpos` then equals the old `holepos`.

Source files
------------

// File: rtl/bar_game_ctrl.sv
// ---------------------------------------------------------------------------
// bar_game_ctrl
// Game-state engine for the falling-bar game. It steps a bar down the screen
// once every `cyclesneeded` frame ticks and checks whether the player column
// lines up with the hole when the bar reaches the bottom. It also tracks
// lives, score and speed, and drives the position/status inputs of the vga
// renderer.
//
// Ports
//   dclk          in   system clock
//   clr           in   asynchronous active-high reset
//   tick          in   one-cycle pulse per video frame
//   btn_l/btn_r   in   debounced move buttons (levels)
//   btn_start     in   debounced start/restart button (level)
//   barpos        out  bar top row, 0..BAR_BOTTOM
//   holepos       out  hole column, 0..15
//   plrpos        out  player column, 0..15
//   lives         out  remaining lives
//   cyclesneeded  out  ticks per bar step, 1..7
//   score         out  bars passed, saturating at 255
//   gameover      out  high while in OVER
// ---------------------------------------------------------------------------
module bar_game_ctrl #(
   parameter int BAR_STEP    = 4,
   parameter int BAR_BOTTOM  = 440,
   parameter int INIT_CYCLES = 4
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       tick,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       btn_start,
   output logic [8:0] barpos,
   output logic [3:0] holepos,
   output logic [3:0] plrpos,
   output logic [1:0] lives,
   output logic [2:0] cyclesneeded,
   output logic [7:0] score,
   output logic       gameover
);

   localparam logic [8:0] BOTTOM = 9'(BAR_BOTTOM);
   localparam logic [9:0] STEP   = 10'(BAR_STEP);
   localparam logic [2:0] CYC0   = 3'(INIT_CYCLES);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t     state, state_next;
   logic [8:0] barpos_next;
   logic [3:0] holepos_next, plrpos_next;
   logic [1:0] lives_next;
   logic [2:0] cyclesneeded_next;
   logic [7:0] score_next, score_inc;
   logic       gameover_next;
   logic [2:0] tickcnt, tickcnt_next;
   logic [7:0] lfsr, lfsr_next;
   logic       btn_l_q, btn_r_q, btn_start_q;
   logic       rise_l, rise_r, rise_start;
   logic [9:0] bar_sum;

   assign rise_l     = btn_l & ~btn_l_q;
   assign rise_r     = btn_r & ~btn_r_q;
   assign rise_start = btn_start & ~btn_start_q;
   // One bit wider so the clamp comparison cannot overflow.
   assign bar_sum    = {1'b0, barpos} + STEP;
   assign score_inc  = (score == 8'hFF) ? score : score + 8'd1;

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         state        <= IDLE;
         barpos       <= '0;
         holepos      <= 4'd5;
         plrpos       <= 4'd7;
         lives        <= 2'd3;
         cyclesneeded <= CYC0;
         score        <= '0;
         gameover     <= 1'b0;
         tickcnt      <= '0;
         lfsr         <= 8'hA5;
         btn_l_q      <= 1'b0;
         btn_r_q      <= 1'b0;
         btn_start_q  <= 1'b0;
      end else begin
         state        <= state_next;
         barpos       <= barpos_next;
         holepos      <= holepos_next;
         plrpos       <= plrpos_next;
         lives        <= lives_next;
         cyclesneeded <= cyclesneeded_next;
         score        <= score_next;
         gameover     <= gameover_next;
         tickcnt      <= tickcnt_next;
         lfsr         <= lfsr_next;
         btn_l_q      <= btn_l;
         btn_r_q      <= btn_r;
         btn_start_q  <= btn_start;
      end
   end

   always_comb begin
      state_next        = state;
      barpos_next       = barpos;
      holepos_next      = holepos;
      plrpos_next       = plrpos;
      lives_next        = lives;
      cyclesneeded_next = cyclesneeded;
      score_next        = score;
      tickcnt_next      = tickcnt;
      // Free-running in every state so the hole sequence depends on player timing.
      lfsr_next         = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      case (state)
         IDLE: begin
            if (rise_start) begin
               holepos_next = lfsr[3:0];
               tickcnt_next = '0;
               state_next   = PLAY;
            end
         end

         PLAY: begin
            // Opposing edges in the same cycle cancel; the ends saturate.
            if (rise_l && !rise_r && plrpos != 4'd0)
               plrpos_next = plrpos - 4'd1;
            else if (rise_r && !rise_l && plrpos != 4'd15)
               plrpos_next = plrpos + 4'd1;

            if (tick) begin
               if (tickcnt != cyclesneeded - 3'd1) begin
                  tickcnt_next = tickcnt + 3'd1;
               end else begin
                  tickcnt_next = '0;
                  if (barpos < BOTTOM) begin
                     barpos_next = (bar_sum > {1'b0, BOTTOM}) ? BOTTOM : bar_sum[8:0];
                  end else if (plrpos == holepos) begin
                     // Crossing uses the pre-move player column.
                     score_next   = score_inc;
                     if (score_inc[1:0] == 2'd0 && cyclesneeded > 3'd1)
                        cyclesneeded_next = cyclesneeded - 3'd1;
                     barpos_next  = '0;
                     holepos_next = lfsr[3:0];
                  end else if (lives > 2'd1) begin
                     lives_next   = lives - 2'd1;
                     barpos_next  = '0;
                     holepos_next = lfsr[3:0];
                  end else begin
                     lives_next = '0;
                     state_next = OVER;
                  end
               end
            end
         end

         OVER: begin
            if (rise_start) begin
               barpos_next       = '0;
               holepos_next      = lfsr[3:0];
               plrpos_next       = 4'd7;
               lives_next        = 2'd3;
               cyclesneeded_next = CYC0;
               score_next        = '0;
               tickcnt_next      = '0;
               state_next        = PLAY;
            end
         end

         default: state_next = IDLE;
      endcase

      gameover_next = (state_next == OVER);
   end

endmodule
